// File: rtl/regfile_mp.sv
// regfile_mp: multi-port MIPS register file with pending-write scoreboard and optional write-to-read bypass
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to rd_data, v0 and a0.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   rd_addr/rd_data/rd_busy   NUM_RD read ports with scoreboard bit of each read address
//   wr_en/wr_addr/wr_data     NUM_WR write ports, higher index wins on address conflict
//   mark_en/mark_addr         set pending bit of a destination register
//   v0, a0                    contents of registers V0_IDX and A0_IDX
//   busy_vec                  full scoreboard
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int V0_IDX = 2,
  parameter int A0_IDX = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic [DATA_W-1:0]        v0,
  output logic [DATA_W-1:0]        a0,
  output logic [2**ADDR_W-1:0]     busy_vec
);
  localparam int DEPTH = 2**ADDR_W;
  // v0 and a0 are handled as two extra lookup ports after the read ports
  localparam int NL = NUM_RD + 2;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W-1:0] la [NL];
  logic [DATA_W-1:0] lv [NL];
  // register 0 is never written, so it stays at its reset value of 0
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++)
      if (wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] != '0) begin
        regs_d[wr_addr[i*ADDR_W +: ADDR_W]] = wr_data[i*DATA_W +: DATA_W];
        busy_d[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    // a new producer issued while the old one retires keeps the register pending
    if (mark_en && mark_addr != '0) busy_d[mark_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) la[p] = rd_addr[p*ADDR_W +: ADDR_W];
    la[NUM_RD]   = ADDR_W'(V0_IDX);
    la[NUM_RD+1] = ADDR_W'(A0_IDX);
  end
  always_comb
    for (int p = 0; p < NL; p++) begin
      lv[p] = regs_q[la[p]];
`ifdef REGFILE_BYPASS_EN
      // ascending scan lets the highest-index matching port win; no forwarding while in reset
      for (int i = 0; i < NUM_WR; i++)
        if (reset_n && wr_en[i] && la[p] != '0 && wr_addr[i*ADDR_W +: ADDR_W] == la[p])
          lv[p] = wr_data[i*DATA_W +: DATA_W];
`endif
    end
  always_comb
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p*DATA_W +: DATA_W] = lv[p];
      rd_busy[p] = busy_q[la[p]];
    end
  assign v0       = lv[NUM_RD];
  assign a0       = lv[NUM_RD+1];
  assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an array-based reference model
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, NW = 2;
  logic clk = 1'b0;
  logic reset_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic [NW-1:0] wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic mark_en;
  logic [AW-1:0] mark_addr;
  logic [DW-1:0] v0, a0;
  logic [31:0] busy_vec;
  int checks = 0, errors = 0;
  logic [DW-1:0] m_reg [32];
  logic m_busy [32];
  logic [31:0] m_busy_vec;
  logic [DW-1:0] exp_v;

  regfile_mp dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en), .mark_addr(mark_addr),
    .v0(v0), .a0(a0), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < NW; i++)
      if (reset_n && wr_en[i] && a != 0 && wr_addr[i*AW +: AW] == a) v = wr_data[i*DW +: DW];
`endif
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_clear();
    else begin
      for (int i = 0; i < NW; i++)
        if (wr_en[i] && wr_addr[i*AW +: AW] != 0) begin
          m_reg[wr_addr[i*AW +: AW]] = wr_data[i*DW +: DW];
          m_busy[wr_addr[i*AW +: AW]] = 1'b0;
        end
      if (mark_en && mark_addr != 0) m_busy[mark_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    mark_en = 1'b0;
    mark_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    wr_en[0] = 1'b1; wr_addr[0 +: AW] = 5; wr_data[0 +: DW] = 32'h1234;
    mark_en = 1'b1; mark_addr = 3;
    tick();
    idle();
    rd_addr[0 +: AW] = 5;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'h1234) begin errors++; $display("FAIL reset_prewrite: got %h want %h", rd_data[0 +: DW], 32'h1234); end
    checks++;
    if (busy_vec !== 32'h8) begin errors++; $display("FAIL reset_premark: got %h want %h", busy_vec, 32'h8); end
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'h0) begin errors++; $display("FAIL reset_async_rd: got %h want 0", rd_data[0 +: DW]); end
    checks++;
    if (v0 !== 32'h0 || a0 !== 32'h0) begin errors++; $display("FAIL reset_v0a0: got %h/%h want 0/0", v0, a0); end
    checks++;
    if (busy_vec !== 32'h0 || rd_busy !== '0) begin errors++; $display("FAIL reset_busy: got %h/%b want 0/0", busy_vec, rd_busy); end
    wr_en[1] = 1'b1; wr_addr[AW +: AW] = 5; wr_data[DW +: DW] = 32'hBAD0BAD0;
    rd_addr[AW +: AW] = 5;
    tick();
    checks++;
    if (rd_data[0 +: DW] !== 32'h0 || rd_data[DW +: DW] !== 32'h0) begin errors++; $display("FAIL reset_abort_write: got %h/%h want 0/0", rd_data[0 +: DW], rd_data[DW +: DW]); end
    idle();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    idle();
    wr_en[0] = 1'b1; wr_addr[0 +: AW] = 2; wr_data[0 +: DW] = 32'hDEADBEEF;
    tick();
    idle();
    wr_en[1] = 1'b1; wr_addr[AW +: AW] = 0; wr_data[DW +: DW] = 32'hFFFF_FFFF;
    rd_addr[0 +: AW] = 2; rd_addr[AW +: AW] = 0;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_reg2: got %h want deadbeef", rd_data[0 +: DW]); end
    checks++;
    if (v0 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_v0: got %h want deadbeef", v0); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[DW +: DW] !== 32'h0) begin errors++; $display("FAIL wr_reg0: got %h want 0", rd_data[DW +: DW]); end
  endtask

  task automatic test_conflict();
    idle();
    wr_en = 2'b11;
    wr_addr[0 +: AW] = 7; wr_data[0 +: DW] = 32'h11;
    wr_addr[AW +: AW] = 7; wr_data[DW +: DW] = 32'h22;
    tick();
    wr_addr[0 +: AW] = 8; wr_data[0 +: DW] = 32'h88;
    wr_addr[AW +: AW] = 9; wr_data[DW +: DW] = 32'h99;
    rd_addr[0 +: AW] = 7;
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'h22) begin errors++; $display("FAIL conflict_same: got %h want 22", rd_data[0 +: DW]); end
    rd_addr[0 +: AW] = 8; rd_addr[AW +: AW] = 9;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'h88 || rd_data[DW +: DW] !== 32'h99) begin errors++; $display("FAIL conflict_diff: got %h/%h want 88/99", rd_data[0 +: DW], rd_data[DW +: DW]); end
  endtask

  task automatic test_scoreboard();
    idle();
    rd_addr[0 +: AW] = 9;
    mark_en = 1'b1; mark_addr = 9;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_mark_same_cycle: got %b want 0", rd_busy[0]); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_mark_next: got %b want 1", rd_busy[0]); end
    wr_en[0] = 1'b1; wr_addr[0 +: AW] = 9; wr_data[0 +: DW] = 32'h55;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_write_cycle: got %b want 1", rd_busy[0]); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[0 +: DW] !== 32'h55) begin errors++; $display("FAIL sb_clear: got %b/%h want 0/55", rd_busy[0], rd_data[0 +: DW]); end
    wr_en[1] = 1'b1; wr_addr[AW +: AW] = 9; wr_data[DW +: DW] = 32'h77;
    mark_en = 1'b1; mark_addr = 9;
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[0 +: DW] !== 32'h77) begin errors++; $display("FAIL sb_mark_wins: got %b/%h want 1/77", rd_busy[0], rd_data[0 +: DW]); end
  endtask

  task automatic test_bypass();
    idle();
    wr_en[0] = 1'b1; wr_addr[0 +: AW] = 4; wr_data[0 +: DW] = 32'h1111;
    tick();
    idle();
    wr_en[1] = 1'b1; wr_addr[AW +: AW] = 4; wr_data[DW +: DW] = 32'hA5A5;
    rd_addr[0 +: AW] = 4;
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'hA5A5;
`else
    exp_v = 32'h1111;
`endif
    #1;
    checks++;
    if (rd_data[0 +: DW] !== exp_v) begin errors++; $display("FAIL bypass_rd: got %h want %h", rd_data[0 +: DW], exp_v); end
    checks++;
    if (a0 !== exp_v) begin errors++; $display("FAIL bypass_a0: got %h want %h", a0, exp_v); end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'hA5A5 || a0 !== 32'hA5A5) begin errors++; $display("FAIL bypass_next: got %h/%h want a5a5", rd_data[0 +: DW], a0); end
  endtask

  task automatic test_mark_zero();
    idle();
    rd_addr[0 +: AW] = 0;
    mark_en = 1'b1; mark_addr = 0;
    tick();
    idle();
    #1;
    checks++;
    if (busy_vec[0] !== 1'b0 || rd_busy[0] !== 1'b0) begin errors++; $display("FAIL mark_zero: got %b/%b want 0/0", busy_vec[0], rd_busy[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NW; i++) begin
        wr_en[i] = 1'($urandom_range(0, 1));
        wr_addr[i*AW +: AW] = AW'($urandom_range(0, 11));
        wr_data[i*DW +: DW] = $urandom;
      end
      mark_en = ($urandom_range(0, 3) == 0);
      mark_addr = AW'($urandom_range(0, 11));
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 11));
      #1;
      for (int p = 0; p < NR; p++) begin
        exp_v = exp_rd(rd_addr[p*AW +: AW]);
        checks++;
        if (rd_data[p*DW +: DW] !== exp_v) begin errors++; $display("FAIL rand_rd%0d it%0d: got %h want %h", p, n, rd_data[p*DW +: DW], exp_v); end
        checks++;
        if (rd_busy[p] !== m_busy[rd_addr[p*AW +: AW]]) begin errors++; $display("FAIL rand_busy%0d it%0d: got %b want %b", p, n, rd_busy[p], m_busy[rd_addr[p*AW +: AW]]); end
      end
      exp_v = exp_rd(2);
      checks++;
      if (v0 !== exp_v) begin errors++; $display("FAIL rand_v0 it%0d: got %h want %h", n, v0, exp_v); end
      exp_v = exp_rd(4);
      checks++;
      if (a0 !== exp_v) begin errors++; $display("FAIL rand_a0 it%0d: got %h want %h", n, a0, exp_v); end
      for (int r = 0; r < 32; r++) m_busy_vec[r] = m_busy[r];
      checks++;
      if (busy_vec !== m_busy_vec) begin errors++; $display("FAIL rand_busy_vec it%0d: got %h want %h", n, busy_vec, m_busy_vec); end
      tick();
    end
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    rd_addr = '0;
    idle();
    model_clear();
    #1;
    checks++;
    if (rd_data !== '0 || busy_vec !== '0 || v0 !== '0 || a0 !== '0) begin errors++; $display("FAIL initial_reset: got %h/%h/%h/%h want 0", rd_data, busy_vec, v0, a0); end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_conflict();
    test_scoreboard();
    test_bypass();
    test_mark_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
